// File: rtl/uart_tx_mmio_if.sv
// Load/store bus seen by the UART transmitter peripheral: one word select per cycle,
// write strobe qualified by sel, combinational read data.
interface uart_tx_mmio_if #(
  parameter int unsigned DATA_WIDTH = 32
) ();
  logic                  sel;
  logic                  we;
  logic [1:0]            addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (
    output sel,
    output we,
    output addr,
    output wdata,
    input  rdata
  );

  modport slave (
    input  sel,
    input  we,
    input  addr,
    input  wdata,
    output rdata
  );
endinterface

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: small TX FIFO feeding a baud-rate serialiser,
// with STATUS and a runtime-programmable divisor on the same bus.
module uart_tx_mmio #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned BAUD_DIV_RST = 434
) (
  input  logic           clk,
  input  logic           reset,
  uart_tx_mmio_if.slave  bus,
  output logic           uart_tx
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } state_e;

  // Register decode
  logic wr_txdata, wr_status, wr_div;

  assign wr_txdata = bus.sel && bus.we && (bus.addr == 2'd0);
  assign wr_status = bus.sel && bus.we && (bus.addr == 2'd1);
  assign wr_div    = bus.sel && bus.we && (bus.addr == 2'd2);

  // TX FIFO
  logic [7:0]      fifo_mem [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic            fifo_empty, fifo_full;
  logic [7:0]      fifo_head;
  logic            pop, push_ok, push_drop;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CntW'(FIFO_DEPTH));
  assign fifo_head  = fifo_mem[rd_ptr_q];

  // A push into a full FIFO still fits when the serialiser frees a slot the same cycle.
  assign push_ok   = wr_txdata && (!fifo_full || pop);
  assign push_drop = wr_txdata && fifo_full && !pop;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_mem[wr_ptr_q] <= bus.wdata[7:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      if (push_ok && !pop) begin
        count_q <= count_q + CntW'(1);
      end else if (pop && !push_ok) begin
        count_q <= count_q - CntW'(1);
      end
    end
  end

  // Control registers
  logic        overflow_q;
  logic [15:0] div_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow_q <= 1'b0;
      div_q      <= 16'(BAUD_DIV_RST);
    end else begin
      if (push_drop) begin
        overflow_q <= 1'b1;
      end else if (wr_status && bus.wdata[3]) begin
        overflow_q <= 1'b0;
      end
      if (wr_div) begin
        div_q <= (bus.wdata[15:0] < 16'd2) ? 16'd2 : bus.wdata[15:0];
      end
    end
  end

  // Serialiser
  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        tx_q, tx_d;
  logic        cnt_zero;
  logic [15:0] reload;

  assign cnt_zero = (cnt_q == 16'd0);
  // Divisor is sampled only at reload, so a mid-frame DIV write never stretches the current bit.
  assign reload   = div_q - 16'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      cnt_q     <= 16'd0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'd0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    pop       = 1'b0;
    unique case (state_q)
      StIdle: begin
        tx_d = 1'b1;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_head;
          tx_d    = 1'b0;
          cnt_d   = reload;
          state_d = StStart;
        end
      end
      StStart: begin
        if (cnt_zero) begin
          tx_d      = shift_q[0];
          cnt_d     = reload;
          bit_idx_d = 3'd0;
          state_d   = StData;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      StData: begin
        if (cnt_zero) begin
          cnt_d = reload;
          if (bit_idx_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = StStop;
          end else begin
            shift_d   = {1'b0, shift_q[7:1]};
            tx_d      = shift_q[1];
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      StStop: begin
        if (cnt_zero) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = fifo_head;
            tx_d    = 1'b0;
            cnt_d   = reload;
            state_d = StStart;
          end else begin
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign uart_tx = tx_q;

  // Read mux
  logic       busy;
  logic [3:0] status_count;

  assign busy         = (state_q != StIdle);
  assign status_count = 4'(count_q);

  always_comb begin
    bus.rdata = '0;
    unique case (bus.addr)
      2'd1:    bus.rdata[7:0]  = {status_count, overflow_q, busy, fifo_full, fifo_empty};
      2'd2:    bus.rdata[15:0] = div_q;
      default: bus.rdata       = '0;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed bench for uart_tx_mmio: records the serial line every cycle and checks
// frames, latency, FIFO/overflow status and reset behaviour against hand-computed values.
module tb_uart_tx_mmio;

  localparam int unsigned HistLen = 4096;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic uart_tx;

  uart_tx_mmio_if #(.DATA_WIDTH(32)) bus ();

  uart_tx_mmio #(
    .DATA_WIDTH  (32),
    .FIFO_DEPTH  (4),
    .BAUD_DIV_RST(434)
  ) dut (
    .clk    (clk),
    .reset  (rst_n),
    .bus    (bus),
    .uart_tx(uart_tx)
  );

  always #5 clk = ~clk;

  // Line history, one sample per falling edge.
  logic        tx_hist [HistLen];
  int unsigned cyc = 0;

  always @(negedge clk) begin
    if (cyc < HistLen) tx_hist[cyc] <= uart_tx;
    cyc <= cyc + 1;
  end

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic hist_at(input int unsigned i);
    if (i < HistLen) return tx_hist[i];
    return 1'bx;
  endfunction

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d, output int unsigned wcyc);
    @(negedge clk);
    wcyc      = cyc;
    bus.sel   = 1'b1;
    bus.we    = 1'b1;
    bus.addr  = a;
    bus.wdata = d;
    @(posedge clk);
    #1;
    bus.sel = 1'b0;
    bus.we  = 1'b0;
  endtask

  task automatic read_check(input logic [1:0] a, input logic [31:0] exp, input string tag);
    logic [31:0] d;
    @(negedge clk);
    bus.sel  = 1'b1;
    bus.we   = 1'b0;
    bus.addr = a;
    #1;
    d       = bus.rdata;
    bus.sel = 1'b0;
    check_eq(tag, d, exp);
  endtask

  task automatic wait_until(input int unsigned t);
    while (cyc < t) @(negedge clk);
  endtask

  // Slots 0..sw-1 last la cycles, slots sw..9 last lb cycles (slot 0 = start, 9 = stop).
  task automatic check_frame(input string tag, input int unsigned s, input logic [7:0] b,
                             input int unsigned la, input int unsigned lb, input int unsigned sw);
    int unsigned pos  = s;
    int unsigned errs = 0;
    logic [7:0]  obs  = 8'h00;
    if (hist_at(s - 1) !== 1'b1) errs++;
    for (int slot = 0; slot < 10; slot++) begin
      int unsigned len = (slot < int'(sw)) ? la : lb;
      logic expbit;
      if (slot == 0) expbit = 1'b0;
      else if (slot == 9) expbit = 1'b1;
      else expbit = b[slot-1];
      for (int unsigned c = 0; c < len; c++) begin
        if (hist_at(pos + c) !== expbit) errs++;
      end
      if (slot >= 1 && slot <= 8) obs[slot-1] = hist_at(pos + len / 2);
      pos += len;
    end
    check_eq({tag, " data"}, {24'd0, obs}, {24'd0, b});
    check_eq({tag, " cycles"}, errs, 0);
  endtask

  function automatic int unsigned count_low(input int unsigned from, input int unsigned len);
    int unsigned z = 0;
    for (int unsigned i = from; i < from + len; i++) begin
      if (hist_at(i) !== 1'b1) z++;
    end
    return z;
  endfunction

  initial begin
    int unsigned n, m, r;
    logic [7:0]  b4 [6];
    b4[0] = 8'h11; b4[1] = 8'h22; b4[2] = 8'h33;
    b4[3] = 8'h44; b4[4] = 8'h55; b4[5] = 8'h66;

    bus.sel   = 1'b0;
    bus.we    = 1'b0;
    bus.addr  = 2'd0;
    bus.wdata = '0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("reset tx", {31'd0, uart_tx}, 32'd1);
    rst_n = 1'b1;

    // 1: reset values, sel=0 has no effect
    read_check(2'd1, 32'h01, "t1 status");
    read_check(2'd2, 32'd434, "t1 div");
    read_check(2'd0, 32'd0, "t1 txdata reads 0");
    read_check(2'd3, 32'd0, "t1 addr3 reads 0");
    @(negedge clk);
    bus.sel = 1'b0; bus.we = 1'b1; bus.addr = 2'd2; bus.wdata = 32'd5;
    @(negedge clk);
    bus.addr = 2'd0; bus.wdata = 32'hA5;
    @(negedge clk);
    bus.we = 1'b0;
    read_check(2'd2, 32'd434, "t1 div sel0");
    read_check(2'd1, 32'h01, "t1 status sel0");
    check_eq("t1 tx idle", {31'd0, uart_tx}, 32'd1);

    // 2: single frame 0xA5, div 4
    bus_write(2'd2, 32'd4, r);
    read_check(2'd2, 32'd4, "t2 div");
    bus_write(2'd0, 32'hA5, n);
    read_check(2'd1, 32'h10, "t2 status queued");
    wait_until(n + 20);
    read_check(2'd1, 32'h05, "t2 status busy");
    wait_until(n + 45);
    read_check(2'd1, 32'h01, "t2 status done");
    check_eq("t2 latency", {31'd0, hist_at(n + 1)}, 32'd1);
    check_frame("t2 frame", n + 2, 8'hA5, 4, 4, 10);

    // 3: back-to-back frames
    bus_write(2'd0, 32'h55, n);
    bus_write(2'd0, 32'h0F, r);
    read_check(2'd1, 32'h14, "t3 status count1");
    wait_until(n + 2 + 45);
    read_check(2'd1, 32'h05, "t3 status count0");
    wait_until(n + 2 + 85);
    read_check(2'd1, 32'h01, "t3 status empty");
    check_frame("t3 frame0", n + 2, 8'h55, 4, 4, 10);
    check_frame("t3 frame1", n + 42, 8'h0F, 4, 4, 10);

    // 4: overflow
    bus_write(2'd0, {24'd0, b4[0]}, n);
    for (int i = 1; i < 6; i++) bus_write(2'd0, {24'd0, b4[i]}, r);
    read_check(2'd1, 32'h4E, "t4 status overflow");
    bus_write(2'd1, 32'h8, r);
    read_check(2'd1, 32'h46, "t4 status cleared");
    wait_until(n + 2 + 200 + 62);
    for (int i = 0; i < 5; i++) begin
      check_frame($sformatf("t4 frame%0d", i), n + 2 + 40 * i, b4[i], 4, 4, 10);
    end
    check_eq("t4 no sixth frame", count_low(n + 2 + 200, 60), 0);
    read_check(2'd1, 32'h01, "t4 status end");

    // 5: divisor clamp and mid-frame change
    bus_write(2'd2, 32'd0, r);
    read_check(2'd2, 32'd2, "t5 div clamp");
    bus_write(2'd0, 32'h3C, n);
    wait_until(n + 2 + 24);
    check_frame("t5 frame div2", n + 2, 8'h3C, 2, 2, 10);
    bus_write(2'd0, 32'hC6, m);
    repeat (9) @(negedge clk);
    bus_write(2'd2, 32'd8, r);
    wait_until(m + 2 + 54);
    check_frame("t5 frame div2to8", m + 2, 8'hC6, 2, 8, 5);
    read_check(2'd2, 32'd8, "t5 div now 8");

    // 6: reset during DATA with two bytes queued
    bus_write(2'd2, 32'd4, r);
    bus_write(2'd0, 32'h00, n);
    bus_write(2'd0, 32'h81, r);
    bus_write(2'd0, 32'h42, r);
    read_check(2'd1, 32'h24, "t6 status queued");
    wait_until(n + 12);
    check_eq("t6 tx low in data", {31'd0, uart_tx}, 32'd0);
    rst_n = 1'b0;
    #1;
    check_eq("t6 tx after reset", {31'd0, uart_tx}, 32'd1);
    read_check(2'd1, 32'h01, "t6 status in reset");
    read_check(2'd2, 32'd434, "t6 div in reset");
    @(negedge clk);
    rst_n = 1'b1;
    r = cyc;
    wait_until(r + 102);
    check_eq("t6 no frames after", count_low(r, 100), 0);
    read_check(2'd1, 32'h01, "t6 status after");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
